acq_timebase_ctrl: RTL
======================

# acq_timebase_ctrl

Acquisition sequencer for the oscilloscope capture path. It turns the 50 MHz system clock into a programmable sample-enable strobe, selected from a fixed timebase table. It runs the arm → pre-trigger → trigger-wait → post-trigger → done sequence and drives write address and enable into the capture RAM. The display side reads the RAM after `done` and releases the block with `ack`.

## Interface

Parameters:
- `ADDR_W`, 10: capture RAM address width; depth N = 2^ADDR_W samples.
- `DATA_W`, 8: ADC sample width.
- `DIV_W`, 16: divider counter width; must hold 5000.

Ports:
- `clk`  in  1: system clock (50 MHz). This is the only clock.
- `rst`  in  1: synchronous, active-high reset.
- `tb_sel`  in  4: timebase select, latched on an accepted arm.
- `arm`  in  1: single-cycle pulse that starts an acquisition.
- `force_trig`  in  1: forces a trigger while in WAIT_TRIG (auto mode).
- `trig_rise`  in  1: 1 selects rising-edge trigger, 0 selects falling-edge.
- `trig_level`  in  DATA_W: trigger threshold, unsigned.
- `adc_data`  in  DATA_W: current ADC sample.
- `ack`  in  1: display has consumed the buffer.
- `sample_en`  out  1: one-cycle strobe at the sample rate; active only while busy.
- `wr_en`  out  1: capture RAM write enable.
- `wr_addr`  out  ADDR_W: capture RAM write address.
- `wr_data`  out  DATA_W: capture RAM write data.
- `trig_addr`  out  ADDR_W: RAM address of the trigger sample; valid while `done`=1.
- `busy`  out  1: high in PRE, WAIT_TRIG and POST.
- `done`  out  1: high in DONE.

## Operation

- States: IDLE, PRE, WAIT_TRIG, POST, DONE.
- Timebase divisor D is taken from `tb_sel` 0..11 = 1, 2, 5, 10, 20, 50, 100, 200, 500, 1000, 2000, 5000. `tb_sel` ≥ 12 clamps to 5000.
- D is latched only on an accepted arm. Changes to `tb_sel` while busy are ignored.
- Tick counter:
  - Counts 0..D-1 and wraps.
  - `sample_en`=1 when count = D-1 and state is PRE, WAIT_TRIG or POST.
  - D=1 gives `sample_en` every cycle.
  - The counter clears to 0 on an accepted arm.
- Write address increments by 1 after each write and wraps N-1 → 0. It is cleared to 0 on an accepted arm.
- IDLE → PRE on `arm`.
- PRE:
  - Writes N/2 samples.
  - After the N/2-th write, moves to WAIT_TRIG.
  - Triggers are not evaluated in PRE.
- WAIT_TRIG:
  - Keeps writing circularly.
  - For each sample, compares it (cur) with the previous sample (prev), including prev taken from PRE.
  - Rising trigger: prev < `trig_level` and cur ≥ `trig_level`.
  - Falling trigger: prev > `trig_level` and cur ≤ `trig_level`.
  - If `force_trig` was seen high on any cycle since the last sample, the next sample is a trigger.
  - On a trigger sample: that sample is written, its address goes to `trig_addr`, and the state becomes POST.
- POST: writes N/2-1 further samples, then moves to DONE. The buffer then holds N/2 pre-trigger samples, the trigger sample, and N/2-1 post-trigger samples. The oldest sample is at `trig_addr` − N/2 mod N.
- DONE:
  - Holds `done`=1. No sampling and no writes.
  - `ack` → IDLE.
  - `arm` → PRE (re-arm). If `arm` and `ack` arrive together, arm wins.
- `arm` while busy is ignored. `ack` outside DONE is ignored. `force_trig` outside WAIT_TRIG is ignored and not remembered.

## Timing

- Reset values: state IDLE; all outputs 0; tick counter 0; D = 1.
- Reset takes effect in any state and aborts an acquisition immediately.
- Arm sampled at cycle t:
  - `busy`=1 from t+1.
  - The counter is 0 at t+1.
  - The first `sample_en` is at cycle t+D.
- `wr_en`, `wr_addr` and `wr_data` are registered one cycle after `sample_en`.
- `wr_data` = `adc_data` captured in the `sample_en` cycle.
- `done` rises one cycle after the last POST write. `busy` falls in the same cycle.
- `ack` at cycle t gives `done`=0 at t+1.

## Structure

- Shared package `scope_pkg` holds:
  - the state enum `acq_state_t`;
  - the 12-entry divisor table constant;
  - `TB_SEL_MAX` = 11.
- Sub-module `sample_tick_gen` holds the programmable divider: inputs `clk`, `rst`, `clr` and `div`; output `tick`. The controller gates `tick` with the state to form `sample_en`.

## Test plan

- **Reset mid-POST (D=1).** Assert `rst` one cycle. Required: all outputs 0 on the next cycle and state IDLE. A following `arm` runs a normal acquisition.
- **Divider spacing, D=5 (`tb_sel`=2).** Arm at cycle 0. Required: `sample_en` at cycles 5, 10, 15, …; first `wr_en` at cycle 6 with `wr_addr`=0.
- **Rising trigger (N=1024, D=1, `trig_level`=0x80).** Ramp `adc_data` from 0x00. Required:
  - no trigger during the first 512 samples;
  - trigger at the first prev < 0x80 ≤ cur in WAIT_TRIG;
  - exactly 511 further writes, then `done`=1 with the correct `trig_addr`.
- **Falling trigger, flat input.** Hold `adc_data` at a constant 0x40 with falling mode. Required: stays in WAIT_TRIG indefinitely. Pulse `force_trig` once: the next sample is the trigger, then POST and DONE follow.
- **Handshake corners.** Send `arm` during PRE: ignored, counters unaffected. Send `ack` in IDLE: ignored. Send `arm` and `ack` in the same cycle in DONE: goes to PRE with `wr_addr` and counter cleared.
- **Table clamp.** `tb_sel`=15 gives D=5000. Change `tb_sel` mid-acquisition: the sample spacing stays unchanged until the next arm.

Source files
------------

// File: rtl/scope_pkg.sv
// -----------------------------------------------------------------------------
// scope_pkg
// Shared definitions for the oscilloscope acquisition path.
//   acq_state_t : acquisition sequencer states
//   TB_SEL_MAX  : highest valid timebase select code
//   DIV_TABLE   : clock divisor per timebase select code (1-2-5 sequence)
//   div_lookup  : timebase select -> divisor, clamping codes above TB_SEL_MAX
// -----------------------------------------------------------------------------
package scope_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRE       = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4
    } acq_state_t;

    localparam int TB_SEL_MAX = 11;

    // Index 0 is the fastest timebase (one sample per system clock).
    localparam logic [0:TB_SEL_MAX][15:0] DIV_TABLE = '{
        16'd1,    16'd2,    16'd5,
        16'd10,   16'd20,   16'd50,
        16'd100,  16'd200,  16'd500,
        16'd1000, 16'd2000, 16'd5000
    };

    // Unused select codes fall back to the slowest timebase.
    function automatic logic [15:0] div_lookup(input logic [3:0] sel);
        logic [15:0] div;
        if (int'(sel) > TB_SEL_MAX) begin
            div = DIV_TABLE[TB_SEL_MAX];
        end else begin
            div = DIV_TABLE[sel];
        end
        return div;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// -----------------------------------------------------------------------------
// sample_tick_gen
// Programmable divider producing the raw sample tick.
// The count runs 0..div-1 and wraps; tick is high while count = div-1, so
// div = 1 yields a tick on every cycle.
// Ports:
//   clk  in  1      : system clock
//   rst  in  1      : synchronous active-high reset (count -> 0)
//   clr  in  1      : synchronous restart of the count at 0
//   div  in  DIV_W  : divisor, must be >= 1
//   tick out 1      : one-cycle strobe at count = div-1
// -----------------------------------------------------------------------------
module sample_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] last;

    assign last = div - DIV_W'(1);
    assign tick = (count == last);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (count >= last) begin
            // ">=" rather than "==" keeps the counter from running off if it
            // ever sits above the terminal value.
            count <= '0;
        end else begin
            count <= count + DIV_W'(1);
        end
    end

endmodule

// File: rtl/acq_timebase_ctrl.sv
// -----------------------------------------------------------------------------
// acq_timebase_ctrl
// Acquisition sequencer for the scope capture path. Generates the sample
// strobe from the selected timebase, runs IDLE -> PRE -> WAIT_TRIG -> POST ->
// DONE and writes samples into the capture RAM as a circular buffer.
// Requires ADDR_W >= 2 so that the post-trigger segment is non-empty.
// Ports:
//   clk        in  1       : system clock
//   rst        in  1       : synchronous active-high reset, aborts acquisition
//   tb_sel     in  4       : timebase select, latched on accepted arm
//   arm        in  1       : start acquisition (IDLE or DONE only)
//   force_trig in  1       : force a trigger while waiting for one
//   trig_rise  in  1       : 1 = rising edge trigger, 0 = falling edge
//   trig_level in  DATA_W  : unsigned trigger threshold
//   adc_data   in  DATA_W  : current ADC sample
//   ack        in  1       : display finished reading the buffer (DONE only)
//   sample_en  out 1       : sample strobe, only while busy
//   wr_en      out 1       : capture RAM write enable
//   wr_addr    out ADDR_W  : capture RAM write address
//   wr_data    out DATA_W  : capture RAM write data
//   trig_addr  out ADDR_W  : address of the trigger sample, valid with done
//   busy       out 1       : PRE, WAIT_TRIG or POST
//   done       out 1       : buffer complete, waiting for ack or re-arm
// -----------------------------------------------------------------------------
module acq_timebase_ctrl
    import scope_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        tb_sel,
    input  logic              arm,
    input  logic              force_trig,
    input  logic              trig_rise,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              ack,
    output logic              sample_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              busy,
    output logic              done
);

    localparam int HALF = 1 << (ADDR_W - 1);
    // Segment counters count samples taken in the current state; these are
    // the values on the final sample of each segment.
    localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(HALF - 1);
    localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(HALF - 2);

    acq_state_t        state;
    logic [DIV_W-1:0]  div_q;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] seg_cnt;
    logic [DATA_W-1:0] prev_smp;
    logic              force_pend;
    logic              tick;
    logic              arm_ok;
    logic              in_busy;
    logic              lvl_hit;
    logic              trig_hit;

    // Arm is only accepted from IDLE or DONE; it restarts the divider so the
    // first strobe lands exactly D cycles after the arm.
    assign arm_ok  = arm && ((state == ST_IDLE) || (state == ST_DONE));
    assign in_busy = (state == ST_PRE) || (state == ST_WAIT_TRIG) || (state == ST_POST);

    sample_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (arm_ok),
        .div  (div_q),
        .tick (tick)
    );

    assign sample_en = tick && in_busy;

    // Edge detection compares the current sample against the one before it;
    // prev_smp is carried over from PRE so the first WAIT_TRIG sample can
    // already trigger. A force seen in this very cycle also counts.
    always_comb begin
        lvl_hit = 1'b0;
        if (trig_rise) begin
            lvl_hit = (prev_smp < trig_level) && (adc_data >= trig_level);
        end else begin
            lvl_hit = (prev_smp > trig_level) && (adc_data <= trig_level);
        end
        trig_hit = lvl_hit || force_pend || force_trig;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            div_q      <= DIV_W'(1);
            waddr      <= '0;
            seg_cnt    <= '0;
            prev_smp   <= '0;
            force_pend <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            trig_addr  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            // Sample stage -> RAM write stage
            wr_en <= sample_en;
            if (sample_en) begin
                wr_addr  <= waddr;
                wr_data  <= adc_data;
                waddr    <= waddr + ADDR_W'(1);
                prev_smp <= adc_data;
            end

            if (arm_ok) begin
                div_q      <= DIV_W'(div_lookup(tb_sel));
                waddr      <= '0;
                seg_cnt    <= '0;
                force_pend <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (arm) begin
                        state <= ST_PRE;
                        busy  <= 1'b1;
                    end
                end

                ST_PRE: begin
                    if (sample_en) begin
                        if (seg_cnt == PRE_LAST) begin
                            state   <= ST_WAIT_TRIG;
                            seg_cnt <= '0;
                        end else begin
                            seg_cnt <= seg_cnt + ADDR_W'(1);
                        end
                    end
                end

                ST_WAIT_TRIG: begin
                    if (sample_en) begin
                        force_pend <= 1'b0;
                        if (trig_hit) begin
                            trig_addr <= waddr;
                            state     <= ST_POST;
                            seg_cnt   <= '0;
                        end
                    end else if (force_trig) begin
                        // Remember a force between strobes for the next sample.
                        force_pend <= 1'b1;
                    end
                end

                ST_POST: begin
                    if (sample_en) begin
                        if (seg_cnt == POST_LAST) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            seg_cnt <= seg_cnt + ADDR_W'(1);
                        end
                    end
                end

                ST_DONE: begin
                    // Re-arm takes priority over ack.
                    if (arm) begin
                        state <= ST_PRE;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end else if (ack) begin
                        state <= ST_IDLE;
                        done  <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
